// File: rtl/lut_req_arbiter.sv
// Round-robin arbiter sharing one lut_core lookup port between N_PE requesters.
// Each issued lookup carries the grantee ID down a tag pipeline so the result returns to that PE only.
module lut_req_arbiter #(
    parameter int N_PE       = 4,
    parameter int DATA_WIDTH = 16,
    parameter int LUT_LAT    = 1,
    parameter int CNT_W      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    configured,
    input  logic [N_PE-1:0]         pe_req_valid,
    input  logic [N_PE*16-1:0]      pe_r2_code,
    output logic [N_PE-1:0]         pe_req_ready,
    output logic [N_PE-1:0]         pe_rsp_valid,
    output logic [DATA_WIDTH-1:0]   pe_rsp_data,
    output logic                    lut_req_valid,
    output logic [15:0]             lut_r2_code,
    input  logic [DATA_WIDTH-1:0]   lut_data_out,
    input  logic                    lut_ready,
    output logic                    busy,
    output logic                    err_sticky,
    output logic [CNT_W-1:0]        issue_cnt
);

    localparam int PTR_W = $clog2(N_PE);
    localparam int IGN_W = $clog2(LUT_LAT + 1);
    localparam logic [PTR_W:0]   N_PE_W  = (PTR_W + 1)'(N_PE);
    localparam logic [PTR_W-1:0] LAST_ID = PTR_W'(N_PE - 1);

    logic [PTR_W-1:0]      rr_ptr_reg;
    logic [15:0]           code_reg;
    logic                  vld_reg [LUT_LAT];
    logic [PTR_W-1:0]      id_reg  [LUT_LAT];
    logic [IGN_W-1:0]      ign_reg;
    logic [N_PE-1:0]       rsp_valid_reg;
    logic [DATA_WIDTH-1:0] rsp_data_reg;
    logic                  err_reg;
    logic [CNT_W-1:0]      issue_cnt_reg;

    logic                  grant_any;
    logic [PTR_W-1:0]      grant_id;
    logic [PTR_W:0]        scan_sum;
    logic [PTR_W-1:0]      scan_idx;
    logic                  last_vld;
    logic [PTR_W-1:0]      last_id;

    // Scan downward so the lowest offset from rr_ptr is written last and wins.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        if (configured && !rst) begin
            for (int k = N_PE - 1; k >= 0; k--) begin
                scan_sum = {1'b0, rr_ptr_reg} + (PTR_W + 1)'(k);
                if (scan_sum >= N_PE_W) begin
                    scan_sum = scan_sum - N_PE_W;
                end
                scan_idx = scan_sum[PTR_W-1:0];
                if (pe_req_valid[scan_idx]) begin
                    grant_any = 1'b1;
                    grant_id  = scan_idx;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_PE; gi++) begin : g_ready
            assign pe_req_ready[gi] = grant_any && (grant_id == PTR_W'(gi));
        end
    endgenerate

    assign lut_req_valid = grant_any;
    assign lut_r2_code   = grant_any ? pe_r2_code[{grant_id, 4'b0000} +: 16] : code_reg;

    assign last_vld = vld_reg[LUT_LAT-1];
    assign last_id  = id_reg[LUT_LAT-1];

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < LUT_LAT; s++) begin
            busy = busy | vld_reg[s];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg    <= '0;
            code_reg      <= '0;
            vld_reg[0]    <= 1'b0;
            id_reg[0]     <= '0;
            ign_reg       <= IGN_W'(LUT_LAT);
            rsp_valid_reg <= '0;
            rsp_data_reg  <= '0;
            err_reg       <= 1'b0;
            issue_cnt_reg <= '0;
        end else begin
            vld_reg[0] <= grant_any;
            id_reg[0]  <= grant_id;
            if (grant_any) begin
                rr_ptr_reg    <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
                code_reg      <= pe_r2_code[{grant_id, 4'b0000} +: 16];
                issue_cnt_reg <= issue_cnt_reg + 1'b1;
            end
            if (ign_reg != '0) begin
                ign_reg <= ign_reg - 1'b1;
            end
            rsp_valid_reg <= '0;
            if (lut_ready && last_vld) begin
                rsp_valid_reg[last_id] <= 1'b1;
                rsp_data_reg           <= lut_data_out;
            end
            // A stray lut_ready right after reset belongs to a lookup that reset discarded.
            if (lut_ready && !last_vld && ign_reg == '0) begin
                err_reg <= 1'b1;
            end
            if (last_vld && !lut_ready) begin
                err_reg <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 1; gi < LUT_LAT; gi++) begin : g_tag
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_reg[gi] <= 1'b0;
                    id_reg[gi]  <= '0;
                end else begin
                    vld_reg[gi] <= vld_reg[gi-1];
                    id_reg[gi]  <= id_reg[gi-1];
                end
            end
        end
    endgenerate

    assign pe_rsp_valid = rsp_valid_reg;
    assign pe_rsp_data  = rsp_data_reg;
    assign err_sticky   = err_reg;
    assign issue_cnt    = issue_cnt_reg;

endmodule

// File: tb/tb_lut_req_arbiter.sv
// Directed bench for lut_req_arbiter with a one-cycle lut_core stand-in (byte swap xor 0x5A5A).
module tb_lut_req_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        configured;
    logic [3:0]  pe_req_valid;
    logic [15:0] code [4];
    logic [63:0] pe_r2_code;
    logic [3:0]  pe_req_ready;
    logic [3:0]  pe_rsp_valid;
    logic [15:0] pe_rsp_data;
    logic        lut_req_valid;
    logic [15:0] lut_r2_code;
    logic [15:0] lut_data_out;
    logic        lut_ready;
    logic        busy;
    logic        err_sticky;
    logic [31:0] issue_cnt;

    logic        mock_rdy = 1'b0;
    logic [15:0] mock_data = 16'h0000;
    logic        spur;

    int checks = 0;
    int failures = 0;
    int gcnt [4];

    always #5 clk = ~clk;

    assign pe_r2_code   = {code[3], code[2], code[1], code[0]};
    assign lut_ready    = mock_rdy | spur;
    assign lut_data_out = mock_data;

    function automatic logic [15:0] g(input logic [15:0] x);
        return {x[7:0], x[15:8]} ^ 16'h5A5A;
    endfunction

    always @(posedge clk) begin
        mock_rdy  <= lut_req_valid;
        mock_data <= g(lut_r2_code);
    end

    lut_req_arbiter #(.N_PE(4), .DATA_WIDTH(16), .LUT_LAT(1), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .configured(configured),
        .pe_req_valid(pe_req_valid), .pe_r2_code(pe_r2_code),
        .pe_req_ready(pe_req_ready), .pe_rsp_valid(pe_rsp_valid), .pe_rsp_data(pe_rsp_data),
        .lut_req_valid(lut_req_valid), .lut_r2_code(lut_r2_code),
        .lut_data_out(lut_data_out), .lut_ready(lut_ready),
        .busy(busy), .err_sticky(err_sticky), .issue_cnt(issue_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; configured = 1'b1; pe_req_valid = 4'hF; spur = 1'b0;
        code[0] = 16'h0011; code[1] = 16'h0122; code[2] = 16'h0233; code[3] = 16'h0344;
        for (int i = 0; i < 4; i++) gcnt[i] = 0;

        // Reset state
        @(negedge clk);
        chk("rst_ready", 32'(pe_req_ready), 32'h0);
        chk("rst_lut_valid", 32'(lut_req_valid), 32'h0);
        next_cycle();
        @(negedge clk);
        chk("rst_rsp_valid", 32'(pe_rsp_valid), 32'h0);
        chk("rst_err", 32'(err_sticky), 32'h0);
        chk("rst_cnt", issue_cnt, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        $display("reset: ready=%b rsp_valid=%b cnt=%0d", pe_req_ready, pe_rsp_valid, issue_cnt);

        // Single request from PE2
        next_cycle();
        rst = 1'b0; pe_req_valid = 4'b0100; code[2] = 16'h01AB;
        @(negedge clk);
        chk("t1_ready", 32'(pe_req_ready), 32'h4);
        chk("t1_lut_valid", 32'(lut_req_valid), 32'h1);
        chk("t1_lut_code", 32'(lut_r2_code), 32'h01AB);
        next_cycle();
        pe_req_valid = 4'b0000;
        @(negedge clk);
        chk("t1_busy", 32'(busy), 32'h1);
        chk("t1_no_rsp_yet", 32'(pe_rsp_valid), 32'h0);
        chk("t1_hold_code", 32'(lut_r2_code), 32'h01AB);
        next_cycle();
        @(negedge clk);
        chk("t1_rsp_valid", 32'(pe_rsp_valid), 32'h4);
        chk("t1_rsp_data", 32'(pe_rsp_data), 32'hF15B);
        chk("t1_cnt", issue_cnt, 32'h1);
        chk("t1_busy_low", 32'(busy), 32'h0);
        $display("single: rsp_valid=%b data=%h cnt=%0d", pe_rsp_valid, pe_rsp_data, issue_cnt);

        // Reset so rr_ptr restarts at 0, then gate with configured=0
        next_cycle();
        rst = 1'b1; configured = 1'b0; pe_req_valid = 4'hF;
        code[2] = 16'h0233;
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) next_cycle();
            @(negedge clk);
            chk("t2_gate_ready", 32'(pe_req_ready), 32'h0);
            chk("t2_gate_lut_valid", 32'(lut_req_valid), 32'h0);
            $display("gate cycle %0d: ready=%b lut_valid=%b", c, pe_req_ready, lut_req_valid);
        end

        // Round robin with all PEs valid for 12 grant cycles, 2 drain cycles
        for (int c = 0; c < 14; c++) begin
            next_cycle();
            configured = 1'b1;
            pe_req_valid = (c < 12) ? 4'hF : 4'h0;
            @(negedge clk);
            for (int p = 0; p < 4; p++) if (pe_req_ready[p]) gcnt[p]++;
            chk("t3_ready", 32'(pe_req_ready), (c < 12) ? (32'h1 << (c % 4)) : 32'h0);
            if (c >= 2) begin
                chk("t3_rsp_valid", 32'(pe_rsp_valid), 32'h1 << ((c - 2) % 4));
                chk("t3_rsp_data", 32'(pe_rsp_data), 32'(g(code[(c - 2) % 4])));
            end else begin
                chk("t3_rsp_idle", 32'(pe_rsp_valid), 32'h0);
            end
            $display("rr cycle %0d: ready=%b rsp_valid=%b data=%h", c, pe_req_ready, pe_rsp_valid, pe_rsp_data);
        end
        for (int p = 0; p < 4; p++) chk("t3_grants_per_pe", 32'(gcnt[p]), 32'd3);
        chk("t3_cnt", issue_cnt, 32'd12);

        // Move rr_ptr to 2 via a single PE1 grant, then PE1+PE3 back to back
        next_cycle();
        pe_req_valid = 4'b0010;
        @(negedge clk);
        chk("t4_pre_ready", 32'(pe_req_ready), 32'h2);
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            pe_req_valid = (c < 8) ? 4'b1010 : 4'b0000;
            @(negedge clk);
            chk("t4_ready", 32'(pe_req_ready), (c < 8) ? ((c % 2 == 0) ? 32'h8 : 32'h2) : 32'h0);
            if (c >= 1) begin
                chk("t4_rsp_valid", 32'(pe_rsp_valid), (c % 2 == 1) ? 32'h2 : 32'h8);
                chk("t4_rsp_data", 32'(pe_rsp_data), 32'(g((c % 2 == 1) ? code[1] : code[3])));
            end
            $display("b2b cycle %0d: ready=%b rsp_valid=%b data=%h", c, pe_req_ready, pe_rsp_valid, pe_rsp_data);
        end

        // Drain on deconfig: two PE0 issues, then configured drops
        next_cycle();
        pe_req_valid = 4'b0001; code[0] = 16'h1234;
        @(negedge clk);
        chk("t5_ready0", 32'(pe_req_ready), 32'h1);
        next_cycle();
        code[0] = 16'hBEEF;
        @(negedge clk);
        chk("t5_ready1", 32'(pe_req_ready), 32'h1);
        next_cycle();
        configured = 1'b0;
        @(negedge clk);
        chk("t5_no_grant", 32'(pe_req_ready), 32'h0);
        chk("t5_no_lut_valid", 32'(lut_req_valid), 32'h0);
        chk("t5_busy", 32'(busy), 32'h1);
        chk("t5_rsp0_valid", 32'(pe_rsp_valid), 32'h1);
        chk("t5_rsp0_data", 32'(pe_rsp_data), 32'h6E48);
        next_cycle();
        @(negedge clk);
        chk("t5_rsp1_valid", 32'(pe_rsp_valid), 32'h1);
        chk("t5_rsp1_data", 32'(pe_rsp_data), 32'hB5E4);
        chk("t5_busy_low", 32'(busy), 32'h0);
        chk("t5_no_grant2", 32'(pe_req_ready), 32'h0);
        next_cycle();
        @(negedge clk);
        chk("t5_rsp_done", 32'(pe_rsp_valid), 32'h0);
        chk("t5_cnt", issue_cnt, 32'd23);
        chk("t5_err", 32'(err_sticky), 32'h0);
        $display("drain: busy=%b rsp_valid=%b cnt=%0d", busy, pe_rsp_valid, issue_cnt);

        // Spurious lut_ready with no tag in flight
        next_cycle();
        pe_req_valid = 4'b0000; spur = 1'b1;
        next_cycle();
        spur = 1'b0;
        @(negedge clk);
        chk("t6_err_set", 32'(err_sticky), 32'h1);
        chk("t6_no_rsp", 32'(pe_rsp_valid), 32'h0);
        $display("spurious: err=%b rsp_valid=%b", err_sticky, pe_rsp_valid);

        // Reset with one lookup in flight
        next_cycle();
        configured = 1'b1; pe_req_valid = 4'b0001;
        @(negedge clk);
        chk("t6_grant", 32'(pe_req_ready), 32'h1);
        next_cycle();
        rst = 1'b1; pe_req_valid = 4'hF;
        @(negedge clk);
        chk("t6_rst_ready", 32'(pe_req_ready), 32'h0);
        chk("t6_rst_lut_valid", 32'(lut_req_valid), 32'h0);
        next_cycle();
        rst = 1'b0; pe_req_valid = 4'h0; spur = 1'b1;
        @(negedge clk);
        chk("t6_post_rsp", 32'(pe_rsp_valid), 32'h0);
        chk("t6_post_err", 32'(err_sticky), 32'h0);
        chk("t6_post_cnt", issue_cnt, 32'h0);
        chk("t6_post_busy", 32'(busy), 32'h0);
        next_cycle();
        spur = 1'b0;
        @(negedge clk);
        chk("t6_ignored_err", 32'(err_sticky), 32'h0);
        chk("t6_ignored_rsp", 32'(pe_rsp_valid), 32'h0);
        next_cycle();
        pe_req_valid = 4'hF;
        @(negedge clk);
        chk("t6_rr_ptr_zero", 32'(pe_req_ready), 32'h1);
        $display("post-reset: err=%b cnt=%0d ready=%b", err_sticky, issue_cnt, pe_req_ready);
        next_cycle();
        pe_req_valid = 4'h0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
